// File: rtl/plot_sink_pkg.sv
// Shared definitions for the plot sink: default picture geometry,
// frame-buffer address width, readout state encoding and the
// coordinate-to-address helper used by both write and read paths.
package plot_sink_pkg;

    localparam int DEF_WIDTH  = 160;
    localparam int DEF_HEIGHT = 120;
    localparam int DEF_CW     = 3;
    localparam int FB_AW      = 15;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        PRESENT
    } scan_state_t;

    // Row-major linear address of pixel (x, y) in a frame of the given width.
    function automatic logic [FB_AW-1:0] xy_to_addr(input logic [7:0] x,
                                                    input logic [6:0] y,
                                                    input int width);
        return FB_AW'(int'(y) * width + int'(x));
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Frame-buffer storage: simple dual-port RAM, one write port and one
// registered read port. No reset, so the picture survives a sink reset.
// A read and a write to the same address in one cycle return the old data.
module fb_ram
    import plot_sink_pkg::*;
#(
    parameter int DEPTH = DEF_WIDTH * DEF_HEIGHT,
    parameter int CW    = DEF_CW
) (
    input  logic             clk,
    input  logic             we,
    input  logic [FB_AW-1:0] waddr,
    input  logic [CW-1:0]    wdata,
    input  logic             re,
    input  logic [FB_AW-1:0] raddr,
    output logic [CW-1:0]    rdata
);

    logic [CW-1:0] mem [DEPTH];

    // Write and read share the edge; non-blocking update gives read-old-data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/plot_sink.sv
// plot_sink: captures vga_plot strobes into a frame buffer and streams
// the picture back in raster order over a valid/ready port.
// Optional feature macro: PLOT_SINK_OOB_CNT_EN adds the oob_count port
// and its saturating counter of rejected out-of-bounds plots.
module plot_sink
    import plot_sink_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int CW     = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    vga_x,
    input  logic [6:0]    vga_y,
    input  logic [CW-1:0] vga_colour,
    input  logic          vga_plot,
    input  logic          scan_start,
    output logic          scan_busy,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [7:0]    pix_x,
    output logic [6:0]    pix_y,
    output logic [CW-1:0] pix_colour,
    output logic          pix_last,
    output logic [15:0]   plot_count
`ifdef PLOT_SINK_OOB_CNT_EN
    ,
    output logic [15:0]   oob_count
`endif
);

    logic             in_bounds;
    logic             accept;
    logic [FB_AW-1:0] wr_addr;
    logic [FB_AW-1:0] rd_addr;
    logic [CW-1:0]    rd_data;
    logic             rd_en;
    logic [7:0]       scan_x;
    logic [6:0]       scan_y;
    logic             at_last;
    logic             x_at_end;
    scan_state_t      state;
    scan_state_t      state_next;

    assign in_bounds = (int'(vga_x) < WIDTH) && (int'(vga_y) < HEIGHT);
    assign accept    = vga_plot && in_bounds;
    assign wr_addr   = xy_to_addr(vga_x, vga_y, WIDTH);
    assign rd_addr   = xy_to_addr(scan_x, scan_y, WIDTH);
    assign rd_en     = (state == READ);
    assign x_at_end  = (scan_x == 8'(WIDTH - 1));
    assign at_last   = x_at_end && (scan_y == 7'(HEIGHT - 1));

    fb_ram #(
        .DEPTH (WIDTH * HEIGHT),
        .CW    (CW)
    ) u_fb_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_addr),
        .wdata (vga_colour),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Readout state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Readout next-state: start from IDLE, READ always lasts one cycle,
    // PRESENT waits for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (scan_start) begin
                    state_next = READ;
                end
            end
            READ: begin
                state_next = PRESENT;
            end
            PRESENT: begin
                if (pix_ready) begin
                    state_next = at_last ? IDLE : READ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Readout outputs; colour and last are masked outside PRESENT so the
    // uninitialised read register never leaks out.
    always_comb begin
        scan_busy  = 1'b0;
        pix_valid  = 1'b0;
        pix_last   = 1'b0;
        pix_colour = '0;
        pix_x      = scan_x;
        pix_y      = scan_y;
        case (state)
            READ: begin
                scan_busy = 1'b1;
            end
            PRESENT: begin
                scan_busy  = 1'b1;
                pix_valid  = 1'b1;
                pix_last   = at_last;
                pix_colour = rd_data;
            end
            default: begin
                scan_busy = 1'b0;
            end
        endcase
    end

    // Scan coordinates: zeroed on start, advanced in raster order per handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_x <= '0;
            scan_y <= '0;
        end else if (state == IDLE && scan_start) begin
            scan_x <= '0;
            scan_y <= '0;
        end else if (state == PRESENT && pix_ready && !at_last) begin
            if (x_at_end) begin
                scan_x <= '0;
                scan_y <= scan_y + 7'd1;
            end else begin
                scan_x <= scan_x + 8'd1;
            end
        end
    end

    // Saturating count of accepted in-bounds plots.
    always_ff @(posedge clk) begin
        if (rst) begin
            plot_count <= '0;
        end else if (accept && plot_count != 16'hFFFF) begin
            plot_count <= plot_count + 16'd1;
        end
    end

`ifdef PLOT_SINK_OOB_CNT_EN
    logic reject;
    assign reject = vga_plot && !in_bounds;

    // Saturating count of plots dropped for lying outside the picture.
    always_ff @(posedge clk) begin
        if (rst) begin
            oob_count <= '0;
        end else if (reject && oob_count != 16'hFFFF) begin
            oob_count <= oob_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_plot_sink.sv
// Testbench for plot_sink: random picture written through the plot port,
// read back through the raster port and compared with a pixel array model.
// Honours PLOT_SINK_OOB_CNT_EN for the optional oob_count port.
module tb_plot_sink;

    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  vga_x = '0;
    logic [6:0]  vga_y = '0;
    logic [2:0]  vga_colour = '0;
    logic        vga_plot = 1'b0;
    logic        scan_start = 1'b0;
    logic        scan_busy;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic [2:0]  pix_colour;
    logic        pix_last;
    logic [15:0] plot_count;
`ifdef PLOT_SINK_OOB_CNT_EN
    logic [15:0] oob_count;
`endif

    logic [2:0] ref_mem [N];
    int         exp_plot = 0;
    int         exp_oob = 0;
    int         checks = 0;
    int         errors = 0;
    bit         bg_en = 1'b0;

    always #5 clk = ~clk;

    plot_sink dut (
        .clk        (clk),
        .rst        (rst),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .scan_start (scan_start),
        .scan_busy  (scan_busy),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .pix_last   (pix_last),
        .plot_count (plot_count)
`ifdef PLOT_SINK_OOB_CNT_EN
        ,
        .oob_count  (oob_count)
`endif
    );

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; when enabled, rewrite a random pixel with its current colour.
    task automatic next_cycle();
        int a;
        if (bg_en) begin
            a          = $urandom_range(N - 1);
            vga_x      = 8'(a % W);
            vga_y      = 7'(a / W);
            vga_colour = ref_mem[a];
            vga_plot   = 1'b1;
            exp_plot++;
        end
        @(negedge clk);
    endtask

    // One plot cycle, updating the model by the sink's acceptance rules.
    task automatic applyStimulus(input int x, input int y, input logic [2:0] c, input bit p);
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = c;
        vga_plot   = p;
        if (p) begin
            if (x < W && y < H) begin
                ref_mem[y * W + x] = c;
                exp_plot++;
            end else begin
                exp_oob++;
            end
        end
        next_cycle();
        vga_plot = 1'b0;
    endtask

    // Start a scan and drain n_pix pixels against the model.
    task automatic run_scan(input int n_pix, input int ready_pct, input int bp_idx,
                            input int start_idx, input int rw_idx);
        int         idx;
        int         waitc;
        int         bp_left;
        bit         abort;
        bit         rw_done;
        bit         rw_pending;
        logic [2:0] rw_new;
        idx        = 0;
        waitc      = 0;
        bp_left    = 10;
        abort      = 1'b0;
        rw_done    = 1'b0;
        rw_pending = 1'b0;
        rw_new     = '0;
        scan_start = 1'b1;
        next_cycle();
        scan_start = 1'b0;
        checkOutput("start_busy_t1", scan_busy, 1);
        checkOutput("start_valid_t1", pix_valid, 0);
        next_cycle();
        checkOutput("start_valid_t2", pix_valid, 1);
        while (idx < n_pix && !abort) begin
            scan_start = 1'b0;
            if (!bg_en) begin
                vga_plot = 1'b0;
            end
            if (pix_valid) begin
                waitc = 0;
                if (idx == start_idx) begin
                    scan_start = 1'b1;
                end
                if (idx == bp_idx && bp_left > 0) begin
                    pix_ready = 1'b0;
                    bp_left--;
                    checkOutput($sformatf("hold%0d_x", idx), pix_x, idx % W);
                    checkOutput($sformatf("hold%0d_y", idx), pix_y, idx / W);
                    checkOutput($sformatf("hold%0d_colour", idx), pix_colour, ref_mem[idx]);
                    checkOutput($sformatf("hold%0d_last", idx), pix_last, 0);
                end else if ($urandom_range(99) < ready_pct) begin
                    pix_ready = 1'b1;
                    checkOutput($sformatf("pix%0d_x", idx), pix_x, idx % W);
                    checkOutput($sformatf("pix%0d_y", idx), pix_y, idx / W);
                    checkOutput($sformatf("pix%0d_colour", idx), pix_colour, ref_mem[idx]);
                    checkOutput($sformatf("pix%0d_last", idx), pix_last, (idx == N - 1) ? 1 : 0);
                    if (idx == rw_idx && rw_pending) begin
                        ref_mem[idx] = rw_new;
                        rw_pending   = 1'b0;
                    end
                    idx++;
                end else begin
                    pix_ready = 1'b0;
                end
            end else begin
                pix_ready = 1'($urandom);
                if (idx == rw_idx && !rw_done && !bg_en) begin
                    rw_new     = ~ref_mem[idx];
                    vga_x      = 8'(idx % W);
                    vga_y      = 7'(idx / W);
                    vga_colour = rw_new;
                    vga_plot   = 1'b1;
                    exp_plot++;
                    rw_done    = 1'b1;
                    rw_pending = 1'b1;
                end
                waitc++;
                if (waitc > 4) begin
                    checkOutput("valid_timeout", 0, 1);
                    abort = 1'b1;
                end
            end
            next_cycle();
        end
        pix_ready  = 1'b0;
        scan_start = 1'b0;
        if (!bg_en) begin
            vga_plot = 1'b0;
        end
    endtask

    initial begin
        int a;
        $display("[TB] plot_sink bench starting");

        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        checkOutput("rst_busy", scan_busy, 0);
        checkOutput("rst_valid", pix_valid, 0);
        checkOutput("rst_last", pix_last, 0);
        checkOutput("rst_plot_count", plot_count, 0);
        checkOutput("rst_pix_x", pix_x, 0);
        checkOutput("rst_pix_y", pix_y, 0);
        checkOutput("rst_colour", pix_colour, 0);
`ifdef PLOT_SINK_OOB_CNT_EN
        checkOutput("rst_oob_count", oob_count, 0);
`endif

        for (int i = 0; i < N; i++) begin
            applyStimulus(i % W, i / W, 3'($urandom), 1'b1);
        end
        checkOutput("fill_count", plot_count, sat16(exp_plot));

        applyStimulus(5, 7, 3'b010, 1'b1);
        checkOutput("single_count", plot_count, sat16(exp_plot));

        applyStimulus(W, 0, 3'b111, 1'b1);
        applyStimulus(0, H, 3'b111, 1'b1);
        checkOutput("bounds_plot_count", plot_count, sat16(exp_plot));
`ifdef PLOT_SINK_OOB_CNT_EN
        checkOutput("bounds_oob_count", oob_count, exp_oob);
`endif

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(W + 20), $urandom_range(H + 7), 3'($urandom),
                          $urandom_range(3) != 0);
        end
        checkOutput("mix_plot_count", plot_count, sat16(exp_plot));
`ifdef PLOT_SINK_OOB_CNT_EN
        checkOutput("mix_oob_count", oob_count, sat16(exp_oob));
`endif

        bg_en = 1'b1;
        run_scan(N, 90, 3, 1000, -1);
        bg_en    = 1'b0;
        vga_plot = 1'b0;
        checkOutput("end_busy", scan_busy, 0);
        checkOutput("end_valid", pix_valid, 0);
        checkOutput("scan_plot_count", plot_count, sat16(exp_plot));

        while (exp_plot < 65540) begin
            a = $urandom_range(N - 1);
            applyStimulus(a % W, a / W, ref_mem[a], 1'b1);
        end
        checkOutput("sat_plot_count", plot_count, sat16(exp_plot));

        run_scan(500, 100, -1, -1, 5);
        next_cycle();
        checkOutput("pre_rst_valid", pix_valid, 1);
        checkOutput("pre_rst_x", pix_x, 500 % W);
        checkOutput("pre_rst_y", pix_y, 500 / W);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_plot = 0;
        exp_oob  = 0;
        checkOutput("midrst_valid", pix_valid, 0);
        checkOutput("midrst_busy", scan_busy, 0);
        checkOutput("midrst_x", pix_x, 0);
        checkOutput("midrst_y", pix_y, 0);
        checkOutput("midrst_last", pix_last, 0);
        checkOutput("midrst_colour", pix_colour, 0);
        checkOutput("midrst_plot_count", plot_count, exp_plot);
`ifdef PLOT_SINK_OOB_CNT_EN
        checkOutput("midrst_oob_count", oob_count, exp_oob);
`endif

        run_scan(20, 100, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/plot_sink.md
# plot_sink

Receiving end of the plot interface driven by the drawing engines (clear, circle/arc, Reuleaux). It captures each `vga_plot` strobe into an internal 160×120×3-bit frame buffer. On request, it streams the buffer back out in raster order over a valid/ready port so the bench or a checker can read the picture back. It sits where the VGA adapter would be, as a cycle-accurate, inspectable model of the pixel sink.

## Interface
- `WIDTH`, default 160: visible columns.
- `HEIGHT`, default 120: visible rows.
- `CW`, default 3: colour bits per pixel.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `vga_x` input 8: plot column.
- `vga_y` input 7: plot row.
- `vga_colour` input CW: plot colour.
- `vga_plot` input 1: write strobe; one pixel per cycle while high.
- `scan_start` input 1: single-cycle request to start a raster readout.
- `scan_busy` output 1: readout in progress.
- `pix_valid` output 1: readout pixel available.
- `pix_ready` input 1: consumer accepts the pixel.
- `pix_x` output 8: column of the presented pixel.
- `pix_y` output 7: row of the presented pixel.
- `pix_colour` output CW: colour of the presented pixel.
- `pix_last` output 1: presented pixel is (WIDTH-1, HEIGHT-1).
- `plot_count` output 16: accepted in-bounds plots since reset, saturating.
- `oob_count` output 16: rejected out-of-bounds plots, saturating. Present only with the macro.

## Operation
- Write path:
  - A plot is accepted when `vga_plot`=1, `vga_x`<WIDTH and `vga_y`<HEIGHT.
  - Address = `vga_y`*WIDTH + `vga_x` (15 bits).
  - Colour is stored at the rising edge of the accepting cycle.
  - Out-of-bounds plots write nothing.
- Write and readout are independent and may occur in the same cycle. A read and a write to the same address in one cycle return the old data.
- Readout FSM:
  - IDLE: `scan_busy`=0, `pix_valid`=0. `scan_start`=1 loads address 0 and goes to READ.
  - READ: issues the synchronous RAM read; `scan_busy`=1. Goes to PRESENT next cycle.
  - PRESENT: `pix_valid`=1; `pix_x`/`pix_y`/`pix_colour`/`pix_last` are held stable while `pix_ready`=0.
    - `pix_ready`=1 and not last: increment x (wrapping to 0, y+1 at WIDTH-1), then go to READ.
    - `pix_ready`=1 and last: go to IDLE.
- `scan_start` outside IDLE is ignored.
- Counters:
  - `plot_count` increments by 1 per accepted plot and saturates at 65535.
  - `oob_count` likewise per rejected plot.
  - Both clear only on `rst`.
- Frame-buffer contents are not cleared by `rst`. The clear engine is responsible for initialising the picture.

## Timing
- Reset: on `rst`=1 at an edge, the following hold from the next cycle regardless of state, including mid-scan:
  - all outputs 0;
  - FSM in IDLE;
  - scan coordinates 0.
- Plot write latency: 1 cycle, so the data is readable from the cycle after the strobe.
- Counter update visible 1 cycle after the strobe.
- `scan_start` at cycle t:
  - `scan_busy`=1 at t+1;
  - first `pix_valid`=1 at t+2.
- Throughput: one pixel per 2 cycles with `pix_ready` held high. A full frame takes 38400 cycles plus 1 cycle of start latency.
- `scan_busy` falls the cycle after the last handshake.

## Configuration
- `PLOT_SINK_OOB_CNT_EN` defined: the `oob_count` port and its counter exist.
- `PLOT_SINK_OOB_CNT_EN` undefined: the port and counter are absent. Out-of-bounds plots are silently dropped; all other behaviour is identical.

## Structure
- Shared package `plot_sink_pkg` holds:
  - `WIDTH`, `HEIGHT`, `CW` defaults;
  - `FB_AW`=15;
  - `scan_state_t` enum {IDLE, READ, PRESENT};
  - an `xy_to_addr` function.
- One sub-module, `fb_ram`: simple dual-port memory with 1 write port and 1 synchronous read port, no reset, WIDTH*HEIGHT×CW.

## Test plan
- Reset: assert `rst` for 2 cycles → `scan_busy`, `pix_valid`, `pix_last`, `plot_count`, `oob_count` all 0; FSM in IDLE.
- Single plot: write (5,7,3'b010), then `scan_start`, drain with `pix_ready`=1 → the pixel at index 1125 shows `pix_x`=5, `pix_y`=7, `pix_colour`=010; `plot_count`=1.
- Bounds: plots at (160,0) and (0,120) → memory unchanged, `plot_count` unchanged, `oob_count`=2 (macro on).
- Backpressure: hold `pix_ready`=0 for 10 cycles on pixel 3 → outputs stable throughout; the next accepted pixel is (4,0); no skipped or duplicated pixel.
- Full scan: 19200 handshakes.
  - `pix_last` is high only on (159,119).
  - `scan_busy`=0 the next cycle.
  - A `scan_start` pulse mid-scan has no effect.
  - 65536+ plots leave `plot_count`=65535.
- Reset mid-scan: `rst` at pixel 500 → `pix_valid`=0 next cycle; a new `scan_start` restarts at (0,0).
